// File: rtl/mem_io_bus_responder_if.sv
// CPU-side byte bus between the cpu top (master) and mem_io_bus_responder (slave).
// Read data is registered in the responder; io_buffer_full is combinational back-pressure.
interface mem_io_bus_responder_if;
  logic [31:0] cpu_mem_a;
  logic        cpu_mem_wr;
  logic [7:0]  cpu_mem_dout;
  logic [7:0]  cpu_mem_din;
  logic        io_buffer_full;

  modport master (
    output cpu_mem_a, cpu_mem_wr, cpu_mem_dout,
    input  cpu_mem_din, io_buffer_full
  );

  modport slave (
    input  cpu_mem_a, cpu_mem_wr, cpu_mem_dout,
    output cpu_mem_din, io_buffer_full
  );
endinterface

// File: rtl/mem_io_bus_responder.sv
// Responder for the CPU byte bus: program RAM, UART TX/RX FIFOs, cycle counter and stop port.
// Define MEM_IO_RX_FIFO_EN to instantiate the RX FIFO; otherwise 0x30000 reads sample rx_data directly.
module mem_io_bus_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH_LOG   = 4,
  parameter int RX_DEPTH_LOG   = 4,
  parameter int FULL_MARGIN    = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  mem_io_bus_responder_if.slave        bus,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  output logic                         program_stop
);

  localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;
  localparam int TX_DEPTH  = 1 << TX_DEPTH_LOG;
  localparam logic [TX_DEPTH_LOG:0] TX_FULL   = {1'b1, {TX_DEPTH_LOG{1'b0}}};
  localparam logic [TX_DEPTH_LOG:0] TX_MARGIN = FULL_MARGIN[TX_DEPTH_LOG:0];

  // ---------------- address decode ----------------
  logic                      io_sel;
  logic [15:0]               io_off;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      io_wr_tx;
  logic                      io_wr_stop;
  logic                      unused_addr_hi;

  assign io_sel         = (bus.cpu_mem_a[17:16] == 2'b11);
  assign io_off         = bus.cpu_mem_a[15:0];
  assign ram_addr       = bus.cpu_mem_a[RAM_ADDR_WIDTH-1:0];
  assign io_wr_tx       = io_sel && bus.cpu_mem_wr && (io_off == 16'h0000);
  assign io_wr_stop     = io_sel && bus.cpu_mem_wr && (io_off == 16'h0004);
  assign unused_addr_hi = ^bus.cpu_mem_a[31:18];

  // ---------------- program RAM ----------------
  logic [7:0] ram [RAM_DEPTH];
  logic [7:0] ram_rd_q;

  // NOTE: the RAM array and its read register carry no reset so they map onto block RAM;
  // reset correctness of cpu_mem_din comes from the reset output select below.
  always_ff @(posedge clk_in) begin
    if (bus.cpu_mem_wr && !io_sel) ram[ram_addr] <= bus.cpu_mem_dout;
    if (!bus.cpu_mem_wr)           ram_rd_q      <= ram[ram_addr];
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]              tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG:0]   tx_wr_ptr_q, tx_wr_ptr_d;
  logic [TX_DEPTH_LOG:0]   tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_DEPTH_LOG:0]   tx_count;
  logic [TX_DEPTH_LOG:0]   tx_free;
  logic                    tx_pop;
  logic                    tx_push;
  logic [7:0]              tx_push_data;
  logic                    stop_pending_q, stop_pending_d;

  assign tx_count           = tx_wr_ptr_q - tx_rd_ptr_q;
  assign tx_free            = TX_FULL - tx_count;
  assign tx_valid           = (tx_count != '0);
  assign tx_data            = tx_valid ? tx_mem[tx_rd_ptr_q[TX_DEPTH_LOG-1:0]] : 8'h00;
  assign bus.io_buffer_full = (tx_free <= TX_MARGIN);
  assign tx_pop             = tx_valid && tx_ready;
  // A full FIFO still takes a byte when the UART drains one in the same cycle.
  assign tx_push      = ((io_wr_tx && !stop_pending_q && (bus.cpu_mem_dout != 8'h00)) || io_wr_stop)
                        && ((tx_count != TX_FULL) || tx_pop);
  assign tx_push_data = io_wr_stop ? 8'h00 : bus.cpu_mem_dout;
  assign tx_wr_ptr_d  = tx_wr_ptr_q + {{TX_DEPTH_LOG{1'b0}}, tx_push};
  assign tx_rd_ptr_d  = tx_rd_ptr_q + {{TX_DEPTH_LOG{1'b0}}, tx_pop};

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_ptr_q[TX_DEPTH_LOG-1:0]] <= tx_push_data;
  end

  // ---------------- RX path ----------------
  logic [7:0] rx_rd_byte;

`ifdef MEM_IO_RX_FIFO_EN
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG;
  localparam logic [RX_DEPTH_LOG:0] RX_FULL = {1'b1, {RX_DEPTH_LOG{1'b0}}};

  logic [7:0]            rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [RX_DEPTH_LOG:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_DEPTH_LOG:0] rx_count;
  logic                  rx_push;
  logic                  rx_pop;
  logic                  io_rd_rx;

  assign io_rd_rx    = io_sel && !bus.cpu_mem_wr && (io_off == 16'h0000);
  assign rx_count    = rx_wr_ptr_q - rx_rd_ptr_q;
  assign rx_ready    = (rx_count != RX_FULL);
  assign rx_push     = rx_valid && rx_ready;
  assign rx_pop      = io_rd_rx && (rx_count != '0);
  assign rx_rd_byte  = (rx_count != '0) ? rx_mem[rx_rd_ptr_q[RX_DEPTH_LOG-1:0]] : 8'h00;
  assign rx_wr_ptr_d = rx_wr_ptr_q + {{RX_DEPTH_LOG{1'b0}}, rx_push};
  assign rx_rd_ptr_d = rx_rd_ptr_q + {{RX_DEPTH_LOG{1'b0}}, rx_pop};

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr_q[RX_DEPTH_LOG-1:0]] <= rx_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
    end
  end
`else
  localparam int unused_rx_depth_log = RX_DEPTH_LOG;

  assign rx_ready   = 1'b0;
  assign rx_rd_byte = rx_valid ? rx_data : 8'h00;
`endif

  // ---------------- read mux, counter, stop ----------------
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cnt_snap_q, cnt_snap_d;
  logic [7:0]  io_rd_q, io_rd_d;
  logic        sel_ram_q, sel_ram_d;
  logic        program_stop_q, program_stop_d;

  assign cnt_d          = cnt_q + 32'd1;
  assign stop_pending_d = stop_pending_q | io_wr_stop;
  assign program_stop_d = program_stop_q | (stop_pending_q && !tx_valid);

  // NOTE: every output of this block gets a default first (hold), so no path leaves it
  // unassigned and no latch is inferred; write cycles leave cpu_mem_din untouched.
  always_comb begin
    io_rd_d    = io_rd_q;
    cnt_snap_d = cnt_snap_q;
    sel_ram_d  = sel_ram_q;
    if (!bus.cpu_mem_wr) begin
      sel_ram_d = !io_sel;
      if (io_sel) begin
        case (io_off)
          16'h0000: io_rd_d = rx_rd_byte;
          16'h0004: begin
            io_rd_d    = cnt_q[7:0];
            cnt_snap_d = cnt_q;
          end
          16'h0005: io_rd_d = cnt_snap_q[15:8];
          16'h0006: io_rd_d = cnt_snap_q[23:16];
          16'h0007: io_rd_d = cnt_snap_q[31:24];
          default:  io_rd_d = 8'h00;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tx_wr_ptr_q    <= '0;
      tx_rd_ptr_q    <= '0;
      stop_pending_q <= 1'b0;
      program_stop_q <= 1'b0;
      cnt_q          <= '0;
      cnt_snap_q     <= '0;
      io_rd_q        <= 8'h00;
      sel_ram_q      <= 1'b0;
    end else begin
      tx_wr_ptr_q    <= tx_wr_ptr_d;
      tx_rd_ptr_q    <= tx_rd_ptr_d;
      stop_pending_q <= stop_pending_d;
      program_stop_q <= program_stop_d;
      cnt_q          <= cnt_d;
      cnt_snap_q     <= cnt_snap_d;
      io_rd_q        <= io_rd_d;
      sel_ram_q      <= sel_ram_d;
    end
  end

  assign bus.cpu_mem_din = sel_ram_q ? ram_rd_q : io_rd_q;
  assign program_stop    = program_stop_q;

endmodule

// File: doc/mem_io_bus_responder.md
# mem_io_bus_responder

Responder end of the CPU byte-wide memory bus. Serves byte reads and writes to the 128 KiB program RAM, and decodes the I/O window (`a[17:16]==2'b11`): UART transmit/receive bytes, the cycle-counter dword and the program-stop port. It sits between the `cpu` top and the UART and board wrapper. It provides the read-next-cycle / write-in-one-cycle contract and the `io_buffer_full` back-pressure the CPU depends on.

## Interface
- `RAM_ADDR_WIDTH`, 17, RAM byte-address bits; RAM depth is 2^RAM_ADDR_WIDTH.
- `TX_DEPTH_LOG`, 4, log2 of the TX FIFO depth.
- `RX_DEPTH_LOG`, 4, log2 of the RX FIFO depth.
- `FULL_MARGIN`, 2, free-entry threshold at which `io_buffer_full` asserts.
- `clk_in` in 1: single clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `cpu_mem_a` in 32: byte address from the CPU.
- `cpu_mem_wr` in 1: 1 = write, 0 = read.
- `cpu_mem_dout` in 8: write data from the CPU.
- `cpu_mem_din` out 8: read data to the CPU, registered.
- `io_buffer_full` out 1: TX FIFO free entries <= FULL_MARGIN.
- `tx_data` out 8: head byte of the TX FIFO.
- `tx_valid` out 1: TX FIFO non-empty.
- `tx_ready` in 1: UART accepts `tx_data` this cycle.
- `rx_data` in 8: byte from the UART.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: RX FIFO not full.
- `program_stop` out 1: sticky; program has halted and the TX FIFO has drained.

## Operation
- Decode: IO = `a[17:16]==2'b11`; otherwise RAM at `a[RAM_ADDR_WIDTH-1:0]`. Every cycle is a transaction, because the CPU drives address 0 when idle.
- RAM write: byte written at the clock edge.
- RAM read: `cpu_mem_din` <= ram[addr] at the edge. If a write and a read target the same address, the read returns the old data.
- IO write 0x30000:
  - Non-zero byte: push it to the TX FIFO.
  - 0x00: ignored.
  - FIFO full: the byte is dropped and `cpu_mem_din` is unaffected.
- IO write 0x30004: push 0x00 to the TX FIFO and set the internal `stop_pending` flag.
  - `program_stop` asserts in the cycle after `stop_pending` is set and the TX FIFO is empty.
  - `program_stop` stays high until reset.
  - Writes to 0x30000 after `stop_pending` are ignored.
- IO read 0x30000:
  - RX FIFO non-empty: pop it and return the head byte next cycle.
  - RX FIFO empty: return 0x00 and do not pop.
- IO read 0x30004: snapshot the 32-bit cycle counter into `cnt_snap` and return `cnt_snap[7:0]`. The byte shows the counter value as of the read cycle.
- IO reads 0x30005, 0x30006, 0x30007: return `cnt_snap` bytes 1, 2 and 3. The snapshot is not refreshed.
- Other IO addresses: reads return 0x00 and writes are ignored.
- Cycle counter: 32-bit, increments every cycle after reset release and wraps at 2^32-1 to 0.
- TX FIFO:
  - Pointers are TX_DEPTH_LOG+1 bits and wrap modulo depth.
  - Push and pop in the same cycle leave the count unchanged.
  - A push to a full FIFO is allowed only when a pop occurs in the same cycle.
  - Pop happens when `tx_valid && tx_ready`.
- RX FIFO: same structure as the TX FIFO. Push happens when `rx_valid && rx_ready`; pop happens on a 0x30000 read.
- `io_buffer_full` is combinational from the current TX count: `(2^TX_DEPTH_LOG - count) <= FULL_MARGIN`.

## Timing
- Read latency: exactly 1 cycle. Address at edge N gives data on `cpu_mem_din` after edge N and valid through edge N+1.
- Write latency: 1 cycle. There is no wait state.
- `tx_valid` rises in the cycle after the push edge.
- `rx_ready` falls in the cycle after the push that fills the RX FIFO.
- Reset values (asynchronous):
  - `cpu_mem_din`=0, `tx_valid`=0, `tx_data`=0, `io_buffer_full`=0, `program_stop`=0, `rx_ready`=1.
  - Counter=0, `cnt_snap`=0, FIFOs empty, `stop_pending`=0.
  - RAM contents are not reset.
- Reset mid-operation: FIFO contents are discarded, a TX byte in flight is abandoned, and no partial state survives.

## Configuration
- `MEM_IO_RX_FIFO_EN` defined: RX FIFO instantiated as described.
- `MEM_IO_RX_FIFO_EN` undefined:
  - No RX storage is instantiated and `rx_ready` is tied 0.
  - 0x30000 reads return `rx_data` if `rx_valid`, else 0x00, registered with 1-cycle latency.
  - No pop handshake is performed.

## Test plan
- RAM: write 0xA5 to 0x00123, then read 0x00123 -> `cpu_mem_din`=0xA5 one cycle after the read address. Reading 0x00124 (never written, init 0) -> 0x00.
- TX:
  - Stimulus: write 0x41, 0x00, 0x42 to 0x30000, with `tx_ready`=1 starting 3 cycles later.
  - Response: `tx_data` sequence 0x41, 0x42 only. `tx_valid` drops after 2 pops.
- Back-pressure:
  - Stimulus: `tx_ready`=0, 14 writes of 0x55 (depth 16).
  - Response: `io_buffer_full`=1 once free entries <= 2. After 2 more writes, a further write is dropped and the FIFO holds 16 entries.
- Counter:
  - Stimulus: read 0x30004..0x30007 starting at cycle 1000 after reset release.
  - Response: the bytes assemble to 1000 (0x000003E8) regardless of the following reads.
- Stop:
  - Stimulus: write 0x2A to 0x30000, write any byte to 0x30004, `tx_ready`=1.
  - Response: UART sees 0x2A, then 0x00. `program_stop` rises the cycle after the FIFO empties. A later 0x30000 write is ignored.
- RX (with `MEM_IO_RX_FIFO_EN`):
  - Stimulus: push 0x31, 0x32, then 3 reads of 0x30000.
  - Response: 0x31, 0x32, 0x00.
  - Assert `rst_in` mid-stream -> all outputs return to reset values immediately.
